fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output reorder buffer for the 32-point radix-2 SDF FFT pipeline. It sits after the last butterfly stage. It accepts the pipeline's serial output stream, which is in bit-reversed index order, and re-emits each 32-sample frame in natural order (X[0] … X[31]) with index and frame markers. It uses a ping-pong pair of 32-entry banks, so frames may arrive back-to-back without stalls.

## Interface
- DW, 14, width of each real/imaginary sample (signed)
- LOGN, 5, log2 of frame length; N = 2^LOGN = 32

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-high reset (asserted = 1, sampled on clk rising edge)
- valid_i  input  1  input sample valid
- data_in_r  input  DW  signed real part, bit-reversed order
- data_in_i  input  DW  signed imaginary part
- valid_o  output  1  output sample valid
- data_out_r  output  DW  signed real part, natural order
- data_out_i  output  DW  signed imaginary part
- index_o  output  LOGN  natural frequency index of the current output
- first_o  output  1  high with index 0
- last_o  output  1  high with index N-1

## Operation
- Storage: 2 banks × N entries × 2·DW bits, register array. Memory contents are not reset.
- Write side:
  - wcnt (LOGN bits) and wbank (1 bit).
  - Each cycle with valid_i=1, store {data_in_r, data_in_i} at bank[wbank][bitrev(wcnt)], where bitrev reverses all LOGN bits. Then increment wcnt.
  - When wcnt wraps from N-1 to 0: set full[wbank] and toggle wbank.
  - valid_i=0 holds wcnt. Gaps of any length are allowed.
- Read side FSM, states IDLE and READ:
  - IDLE: if full[rbank]=1, go to READ with rcnt=0.
  - READ: each cycle, register bank[rbank][rcnt] onto the data outputs and set valid_o=1, index_o=rcnt, first_o=(rcnt==0), last_o=(rcnt==N-1). Then increment rcnt.
  - At rcnt==N-1: clear full[rbank], toggle rbank, and wrap rcnt to 0. If full of the other bank is set (or being set in the same cycle), stay in READ with no bubble. Otherwise go to IDLE.
  - IDLE drives valid_o=0, first_o=0, last_o=0. Data and index hold their last values.
- Throughput: reading a frame takes exactly N cycles, and writing one takes at least N cycles. The writer therefore never targets a full bank. No backpressure exists, and none is needed.
- Simultaneous events:
  - A full flag set by the writer and a full flag cleared by the reader on the same edge always involve different banks. Both take effect.
  - The reader's IDLE→READ decision uses full[rbank] registered, and sees the writer's set one cycle later.
- Data pass through bit-exact: no scaling, rounding or sign change.

## Timing
- Reset (rst_n=1 at an edge):
  - valid_o=0, first_o=0, last_o=0, data_out_r=0, data_out_i=0, index_o=0.
  - wcnt=0, wbank=0, rbank=0, full=2'b00, FSM=IDLE.
  - A partial frame in progress is discarded. A frame being read out is aborted immediately; outputs go invalid the next cycle.
- Latency: the Nth sample of a frame is captured at edge E, and full is set at E. The FSM enters READ at E+1. The first output (index 0) is registered at E+2. The last output (index 31) is at E+N+1.
- Continuous input (valid_i stuck at 1): after the initial latency, valid_o stays high continuously, 32 samples per frame, with first_o/last_o marking frame boundaries.
- Gapped input: output for a frame starts only after its last sample is received. Output is then always 32 contiguous cycles.

## Test plan
- Single frame, continuous: drive 32 samples, where input position p carries r=bitrev(p), i=-bitrev(p). Required response: 32 contiguous valid_o cycles, starting 2 cycles after the last input edge, with data_out_r=k, data_out_i=-k, and index_o=k for k=0..31. first_o is high only at k=0 and last_o only at k=31.
- Back-to-back frames: drive 4 frames with valid_i held high, frame f using r=100·f+bitrev(p). Required response: 128 contiguous valid_o cycles with no bubble, in natural order per frame and frames in order.
- Gapped input: the same frame, but valid_i toggles 1,0,0 for each sample. Required response: output identical to the single-frame test, starting 2 cycles after the 32nd accepted sample.
- Extremes: sample values r=+8191, i=-8192 at input position 1 (bitrev → index 16), zeros elsewhere. Required response: index 16 outputs +8191/-8192 bit-exact, and all other indices output 0.
- Reset mid-operation: assert rst_n for 1 cycle at output index 10 of frame 0, while frame 1 is half written. Required response: valid_o=0 the next cycle, all outputs at reset values. A fresh frame then sent produces correct natural-order output, with no residue from frames 0 or 1.
- Reset during partial write: assert reset after 20 input samples, then send a full frame. Required response: exactly one output frame, matching the new data.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// Stream bundle for the FFT output reorder buffer: bit-reversed input side
// and natural-order output side with index and frame markers.
interface fft_out_reorder_if #(
  parameter int DW   = 14,
  parameter int LOGN = 5
);
  logic                   valid_i;
  logic signed [DW-1:0]   data_in_r;
  logic signed [DW-1:0]   data_in_i;
  logic                   valid_o;
  logic signed [DW-1:0]   data_out_r;
  logic signed [DW-1:0]   data_out_i;
  logic        [LOGN-1:0] index_o;
  logic                   first_o;
  logic                   last_o;

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, data_out_r, data_out_i, index_o, first_o, last_o
  );

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, data_out_r, data_out_i, index_o, first_o, last_o
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT output into one bank while
// the other bank is read out in natural order, so frames can stream back-to-back.
module fft_out_reorder #(
  parameter int DW   = 14,
  parameter int LOGN = 5
) (
  input logic               clk,
  input logic               rst_n,
  fft_out_reorder_if.slave  bus
);
  localparam int N = 1 << LOGN;

  typedef enum logic {IDLE, READ} state_t;

  logic [2*DW-1:0] mem [2][N];

  logic [LOGN-1:0] wcnt;
  logic            wbank;
  logic [1:0]      full;
  logic [1:0]      full_next;

  state_t          state;
  logic [LOGN-1:0] rcnt;
  logic            rbank;

  logic            valid_q;
  logic            first_q;
  logic            last_q;
  logic [LOGN-1:0] index_q;
  logic [2*DW-1:0] data_q;

  logic            wr_done;
  logic            rd_done;
  logic            cont;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < LOGN; b++) begin
      r[b] = a[LOGN-1-b];
    end
    return r;
  endfunction

  assign wr_done = bus.valid_i && (wcnt == '1);
  assign rd_done = (state == READ) && (rcnt == '1);
  // The writer's set of the other bank on this very edge must also keep READ going.
  assign cont    = full[~rbank] || (wr_done && (wbank != rbank));

  always_comb begin
    full_next = full;
    if (wr_done) full_next[wbank] = 1'b1;
    if (rd_done) full_next[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n && bus.valid_i) begin
      mem[wbank][bitrev(wcnt)] <= {bus.data_in_r, bus.data_in_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      full  <= '0;
    end else begin
      full <= full_next;
      if (bus.valid_i) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == '1) wbank <= ~wbank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      rcnt    <= '0;
      rbank   <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          if (full[rbank]) begin
            state <= READ;
            rcnt  <= '0;
          end
        end
        READ: begin
          data_q  <= mem[rbank][rcnt];
          valid_q <= 1'b1;
          index_q <= rcnt;
          first_q <= (rcnt == '0);
          last_q  <= (rcnt == '1);
          rcnt    <= rcnt + 1'b1;
          if (rcnt == '1) begin
            rbank <= ~rbank;
            if (!cont) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.first_o    = first_q;
  assign bus.last_o     = last_q;
  assign bus.index_o    = index_q;
  assign bus.data_out_r = data_q[2*DW-1:DW];
  assign bus.data_out_i = data_q[DW-1:0];
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: natural-order output, latency,
// back-to-back streaming, gaps, extremes and reset behaviour.
module tb_fft_out_reorder;
  localparam int DW   = 14;
  localparam int LOGN = 5;

  typedef struct {
    int cyc;
    int r;
    int i;
    int idx;
    int first;
    int last;
  } rec_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   last_edge;
  int   total;
  int   bad;
  int   e;
  rec_t q[$];

  fft_out_reorder_if #(.DW(DW), .LOGN(LOGN)) bus ();

  fft_out_reorder #(.DW(DW), .LOGN(LOGN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      rec_t t;
      t.cyc   = cyc;
      t.r     = int'(bus.data_out_r);
      t.i     = int'(bus.data_out_i);
      t.idx   = int'(bus.index_o);
      t.first = int'(bus.first_o);
      t.last  = int'(bus.last_o);
      q.push_back(t);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "test done: total=%0d bad=%0d", total, bad + 1);
  end

  function automatic int br(input int p);
    int r;
    r = 0;
    for (int b = 0; b < LOGN; b++) begin
      if ((p & (1 << b)) != 0) r = r | (1 << (LOGN - 1 - b));
    end
    return r;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int r, input int i);
    @(posedge clk);
    #1;
    bus.valid_i   = v;
    bus.data_in_r = r[DW-1:0];
    bus.data_in_i = i[DW-1:0];
    if (v) last_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 0, 0);
  endtask

  task automatic send_frame(input int base, input int gap);
    for (int p = 0; p < 32; p++) begin
      drive(1'b1, base + br(p), -(base + br(p)));
      idle(gap);
    end
  endtask

  // Expected: natural index k carries base+k / -(base+k), contiguous from start.
  task automatic check_frame(input string name, input int s0, input int start, input int base);
    for (int k = 0; k < 32; k++) begin
      if (s0 + k < q.size()) begin
        check($sformatf("%s_cyc%0d", name, k),   q[s0+k].cyc,   start + k);
        check($sformatf("%s_r%0d", name, k),     q[s0+k].r,     base + k);
        check($sformatf("%s_i%0d", name, k),     q[s0+k].i,     -(base + k));
        check($sformatf("%s_idx%0d", name, k),   q[s0+k].idx,   k);
        check($sformatf("%s_first%0d", name, k), q[s0+k].first, (k == 0) ? 1 : 0);
        check($sformatf("%s_last%0d", name, k),  q[s0+k].last,  (k == 31) ? 1 : 0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, int'(bus.valid_o), 0);
    check({name, "_first"}, int'(bus.first_o), 0);
    check({name, "_last"},  int'(bus.last_o), 0);
    check({name, "_r"},     int'(bus.data_out_r), 0);
    check({name, "_i"},     int'(bus.data_out_i), 0);
    check({name, "_idx"},   int'(bus.index_o), 0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    last_edge     = 0;
    rst_n         = 1'b1;
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle(3);

    // Single frame, continuous
    q.delete();
    send_frame(0, 0);
    e = last_edge;
    idle(45);
    check("single_count", q.size(), 32);
    check_frame("single", 0, e + 2, 0);

    // Four back-to-back frames
    q.delete();
    for (int f = 0; f < 4; f++) begin
      send_frame(100 * f, 0);
      if (f == 0) e = last_edge;
    end
    idle(150);
    check("b2b_count", q.size(), 128);
    for (int f = 0; f < 4; f++) begin
      check_frame($sformatf("b2b%0d", f), 32 * f, e + 2 + 32 * f, 100 * f);
    end

    // Gapped input, valid pattern 1,0,0
    q.delete();
    for (int p = 0; p < 32; p++) begin
      drive(1'b1, br(p), -br(p));
      if (p == 31) e = last_edge;
      idle(2);
    end
    idle(45);
    check("gap_count", q.size(), 32);
    check_frame("gap", 0, e + 2, 0);

    // Extremes at input position 1 -> natural index 16
    q.delete();
    for (int p = 0; p < 32; p++) begin
      if (p == 1) drive(1'b1, 8191, -8192);
      else        drive(1'b1, 0, 0);
    end
    idle(45);
    check("ext_count", q.size(), 32);
    for (int k = 0; k < 32; k++) begin
      if (k < q.size()) begin
        check($sformatf("ext_idx%0d", k), q[k].idx, k);
        check($sformatf("ext_r%0d", k),   q[k].r,   (k == 16) ? 8191 : 0);
        check($sformatf("ext_i%0d", k),   q[k].i,   (k == 16) ? -8192 : 0);
      end
    end

    // Reset while frame 0 is at output index 10 and frame 1 is partly written
    q.delete();
    send_frame(0, 0);
    for (int p = 0; p <= 12; p++) begin
      drive(1'b1, 100 + br(p), -(100 + br(p)));
      if (p == 12) rst_n = 1'b1;
    end
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_count", q.size(), 11);
    if (q.size() > 0) check("midrst_lastidx", q[q.size()-1].idx, 10);
    idle(40);
    check("midrst_quiet", q.size(), 11);
    q.delete();
    send_frame(500, 0);
    e = last_edge;
    idle(45);
    check("fresh_count", q.size(), 32);
    check_frame("fresh", 0, e + 2, 500);

    // Reset after 20 samples of a partial frame
    q.delete();
    for (int p = 0; p < 20; p++) drive(1'b1, 700 + br(p), -(700 + br(p)));
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    send_frame(900, 0);
    e = last_edge;
    idle(80);
    check("partial_count", q.size(), 32);
    check_frame("partial", 0, e + 2, 900);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
